// File: rtl/uart_tx_bridge.sv
// uart_tx_bridge: byte FIFO draining into the MiniUART DATA register as a WISHBONE master.
// Define UART_TX_BRIDGE_IRQ_EN to add the irq_done completion pulse.
module uart_tx_bridge #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned GUARD_CYCLES = 4,
    parameter logic [2:0]  ADDR_DATA    = 3'b000,
    parameter logic [2:0]  ADDR_LSR     = 3'b001,
    parameter int unsigned LSR_TS_BIT   = 5
) (
    input  logic                     CLK_I,
    input  logic                     RST_I,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     ovf_clr,
    output logic [2:0]               ADD_O,
    output logic [31:0]              DAT_O,
    input  logic [31:0]              DAT_I,
    output logic                     STB_O,
    output logic                     WE_O,
    input  logic                     ACK_I,
    output logic                     busy
`ifdef UART_TX_BRIDGE_IRQ_EN
    ,
    output logic                     irq_done
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(GUARD_CYCLES) + 1;

    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES - 1);
    localparam logic [GW-1:0] GUARD_ONE  = GW'(1);

    typedef enum logic [1:0] {
        IDLE,
        POLL,
        WRITE,
        GUARD
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [GW-1:0]   guard_cnt;
    logic [GW-1:0]   guard_nxt;
    logic            push;
    logic            pop;
    logic            ts_idle;
    logic            unused_dat;

    assign ts_idle    = DAT_I[LSR_TS_BIT];
    assign unused_dat = ^DAT_I;

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);
    assign push  = wr_en && !full;
    assign pop   = (state == WRITE) && ACK_I;
    assign busy  = (state != IDLE) || !empty;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + CNT_ONE;
            else if (pop && !push)
                count <= count - CNT_ONE;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    // A push refused while full wins over a clear in the same cycle
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I)
            overflow <= 1'b0;
        else if (wr_en && full)
            overflow <= 1'b1;
        else if (ovf_clr)
            overflow <= 1'b0;
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state     <= IDLE;
            guard_cnt <= '0;
        end else begin
            state     <= state_nxt;
            guard_cnt <= guard_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        guard_nxt = guard_cnt;
        unique case (state)
            IDLE: begin
                if (!empty)
                    state_nxt = POLL;
            end
            POLL: begin
                if (ACK_I && ts_idle)
                    state_nxt = WRITE;
            end
            WRITE: begin
                if (ACK_I) begin
                    state_nxt = GUARD;
                    guard_nxt = GUARD_LOAD;
                end
            end
            GUARD: begin
                if (guard_cnt == '0)
                    state_nxt = IDLE;
                else
                    guard_nxt = guard_cnt - GUARD_ONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bus outputs depend only on the state register so reset drops them at once
    always_comb begin
        STB_O = 1'b0;
        WE_O  = 1'b0;
        ADD_O = '0;
        DAT_O = '0;
        unique case (1'b1)
            (state == POLL): begin
                STB_O = 1'b1;
                ADD_O = ADDR_LSR;
            end
            (state == WRITE): begin
                STB_O = 1'b1;
                WE_O  = 1'b1;
                ADD_O = ADDR_DATA;
                DAT_O = {24'h0, mem[rd_ptr]};
            end
            default: ;
        endcase
    end

`ifdef UART_TX_BRIDGE_IRQ_EN
    // GUARD never pops, so the FIFO is empty after this edge iff nothing is pushed now
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I)
            irq_done <= 1'b0;
        else
            irq_done <= (state == GUARD) && (guard_cnt == '0) &&
                        empty && !push;
    end
`endif

endmodule

// File: tb/tb_uart_tx_bridge.sv
// tb_uart_tx_bridge: directed and random stimulus against a queue-based
// behavioural model of uart_tx_bridge, checked every cycle on the falling edge.
module tb_uart_tx_bridge;

    localparam int DEPTH = 16;
    localparam int G     = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          CLK_I = 1'b0;
    logic          RST_I;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          ovf_clr;
    logic [2:0]    ADD_O;
    logic [31:0]   DAT_O;
    logic [31:0]   DAT_I;
    logic          STB_O;
    logic          WE_O;
    logic          ACK_I;
    logic          busy;
`ifdef UART_TX_BRIDGE_IRQ_EN
    logic          irq_done;
`endif

    logic          ack_en;
    logic          lsr_ts;
    logic [31:0]   lsr_junk;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx_bridge #(
        .DEPTH(DEPTH),
        .GUARD_CYCLES(G),
        .ADDR_DATA(3'b000),
        .ADDR_LSR(3'b001),
        .LSR_TS_BIT(5)
    ) dut (
        .CLK_I(CLK_I),
        .RST_I(RST_I),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .full(full),
        .empty(empty),
        .count(count),
        .overflow(overflow),
        .ovf_clr(ovf_clr),
        .ADD_O(ADD_O),
        .DAT_O(DAT_O),
        .DAT_I(DAT_I),
        .STB_O(STB_O),
        .WE_O(WE_O),
        .ACK_I(ACK_I),
        .busy(busy)
`ifdef UART_TX_BRIDGE_IRQ_EN
        ,
        .irq_done(irq_done)
`endif
    );

    always #5 CLK_I = ~CLK_I;

    // UART slave: ACK follows STB when enabled; LSR read carries ts on bit 5
    assign ACK_I = STB_O & ack_en;
    assign DAT_I = (STB_O && !WE_O) ?
                   ((lsr_junk & ~32'h20) | {26'h0, lsr_ts, 5'h0}) : 32'h0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model state, owned by the compare process
    logic [7:0] mq[$];
    logic [7:0] wlog_d[$];
    int         wlog_c[$];
    bit         movf;
    bit         pend_w;
    int         age = 1000;
    int         prev_mc;
    int         mc;
    int         cyc;
    int         irq_cnt;
    int         last_wr;
    bit         have_last;
    bit         e_stb;
    bit         e_busy;
    bit         ack;
    logic [31:0] e_dat;
    logic [2:0]  e_add;

    initial begin
        forever begin
            @(negedge CLK_I);
            cyc++;
            if (RST_I) begin
                mq.delete();
                movf      = 0;
                pend_w    = 0;
                age       = 1000;
                prev_mc   = 0;
                have_last = 0;
            end else begin
                mc     = mq.size();
                e_stb  = pend_w || (prev_mc > 0 && age >= G + 2);
                e_add  = pend_w ? 3'b000 : (e_stb ? 3'b001 : 3'b000);
                e_dat  = (pend_w && mc > 0) ? {24'h0, mq[0]} : 32'h0;
                e_busy = (mc > 0) || (age >= 1 && age <= G);
                chk("count", 32'(count), 32'(mc));
                chk("empty", 32'(empty), 32'(mc == 0));
                chk("full", 32'(full), 32'(mc == DEPTH));
                chk("overflow", 32'(overflow), 32'(movf));
                chk("stb", 32'(STB_O), 32'(e_stb));
                chk("we", 32'(WE_O), 32'(pend_w));
                chk("add", 32'(ADD_O), 32'(e_add));
                chk("dat", DAT_O, e_dat);
                chk("busy", 32'(busy), 32'(e_busy));
`ifdef UART_TX_BRIDGE_IRQ_EN
                chk("irq", 32'(irq_done), 32'(age == G + 1 && mc == 0));
                if (irq_done)
                    irq_cnt++;
`endif
                if (STB_O && WE_O && ACK_I) begin
                    wlog_d.push_back(DAT_O[7:0]);
                    wlog_c.push_back(cyc);
                    if (have_last)
                        chk("spacing", 32'(cyc - last_wr >= G + 3), 1);
                    last_wr   = cyc;
                    have_last = 1;
                end
                ack     = e_stb && ack_en;
                prev_mc = mc;
                if (pend_w && ack) begin
                    void'(mq.pop_front());
                    pend_w = 0;
                    age    = 1;
                end else begin
                    if (age < 1000)
                        age++;
                    if (!pend_w && e_stb && ack && lsr_ts)
                        pend_w = 1;
                end
                if (wr_en && mc == DEPTH)
                    movf = 1;
                else if (ovf_clr)
                    movf = 0;
                if (wr_en && mc != DEPTH)
                    mq.push_back(wr_data);
            end
        end
    end

    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic wait_idle(input int maxc, input string nm);
        for (int i = 0; i < maxc && busy; i++)
            tick();
        chk(nm, 32'(busy), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] exp4 [16];
    int base;
    int polls;
    bit saw_w;

    initial begin
        RST_I    = 1;
        wr_en    = 0;
        wr_data  = 0;
        ovf_clr  = 0;
        ack_en   = 1;
        lsr_ts   = 1;
        lsr_junk = 0;
        repeat (3) @(posedge CLK_I);
        #1;
        chk("rst_stb", 32'(STB_O), 0);
        chk("rst_we", 32'(WE_O), 0);
        chk("rst_add", 32'(ADD_O), 0);
        chk("rst_dat", DAT_O, 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_ovf", 32'(overflow), 0);
        RST_I = 0;
        tick();
        chk("rst_count", 32'(count), 0);
        chk("rst_busy", 32'(busy), 0);

        // single byte, zero-wait ACK, LSR = 0x20
        wr_en   = 1;
        wr_data = 8'h41;
        tick();
        wr_en = 0;
        chk("t1_cnt", 32'(count), 1);
        chk("t1_idle", 32'(STB_O), 0);
        tick();
        chk("t1_poll_stb", 32'(STB_O), 1);
        chk("t1_poll_we", 32'(WE_O), 0);
        chk("t1_poll_add", 32'(ADD_O), 1);
        tick();
        chk("t1_wr_we", 32'(WE_O), 1);
        chk("t1_wr_add", 32'(ADD_O), 0);
        chk("t1_wr_dat", DAT_O, 32'h41);
        tick();
        chk("t1_g_stb", 32'(STB_O), 0);
        chk("t1_g_dat", DAT_O, 0);
        chk("t1_g_empty", 32'(empty), 1);
        chk("t1_g_busy", 32'(busy), 1);
        repeat (G - 1) tick();
        chk("t1_last_busy", 32'(busy), 1);
        tick();
        chk("t1_done_busy", 32'(busy), 0);
`ifdef UART_TX_BRIDGE_IRQ_EN
        chk("t1_irq", 32'(irq_done), 1);
`endif
        tick();

        // four back-to-back pushes
        base = wlog_d.size();
        for (int i = 0; i < 4; i++) begin
            wr_en   = 1;
            wr_data = 8'(8'h10 + i);
            tick();
        end
        wr_en = 0;
        wait_idle(80, "t2_idle");
        chk("t2_n", 32'(wlog_d.size() - base), 4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < wlog_d.size()) begin
                chk("t2_data", 32'(wlog_d[base+i]), 32'(8'h10 + i));
                if (i > 0)
                    chk("t2_gap", 32'(wlog_c[base+i] - wlog_c[base+i-1]), 7);
            end
        end

        // ten busy LSR polls before the eleventh reports idle
        lsr_ts  = 0;
        wr_en   = 1;
        wr_data = 8'h5A;
        tick();
        wr_en = 0;
        polls = 0;
        saw_w = 0;
        for (int c = 0; c < 60 && !saw_w; c++) begin
            tick();
            if (WE_O)
                saw_w = 1;
            else if (STB_O) begin
                polls++;
                lsr_ts = (polls >= 11);
            end
        end
        chk("t3_write", 32'(saw_w), 1);
        chk("t3_polls", 32'(polls), 11);
        chk("t3_cnt_w", 32'(count), 1);
        chk("t3_dat", DAT_O, 32'h5A);
        tick();
        chk("t3_cnt_after", 32'(count), 0);
        lsr_ts = 1;
        wait_idle(40, "t3_idle");

        // fill to full with the UART stalled, overflow, then drain
        lsr_ts = 0;
        for (int i = 0; i < 17; i++) begin
            wr_en   = 1;
            wr_data = 8'(8'hA0 + 3 * i);
            if (i < 16)
                exp4[i] = 8'(8'hA0 + 3 * i);
            tick();
        end
        chk("t4_count", 32'(count), 16);
        chk("t4_full", 32'(full), 1);
        chk("t4_ovf", 32'(overflow), 1);
        wr_data = 8'hEE;
        ovf_clr = 1;
        tick();
        chk("t4_ovf_prio", 32'(overflow), 1);
        chk("t4_count2", 32'(count), 16);
        wr_en = 0;
        tick();
        ovf_clr = 0;
        chk("t4_ovf_clr", 32'(overflow), 0);
        base   = wlog_d.size();
        lsr_ts = 1;
        wait_idle(300, "t4_idle");
        chk("t4_n", 32'(wlog_d.size() - base), 16);
        for (int i = 0; i < 16; i++) begin
            if (base + i < wlog_d.size())
                chk("t4_data", 32'(wlog_d[base+i]), 32'(exp4[i]));
        end

        // asynchronous reset while a write is on the bus
        for (int i = 0; i < 3; i++) begin
            wr_en   = 1;
            wr_data = 8'(8'hC0 + i);
            tick();
        end
        wr_en = 0;
        for (int c = 0; c < 20 && !WE_O; c++)
            tick();
        chk("t5_inwrite", 32'(WE_O), 1);
        chk("t5_queued", 32'(count), 3);
        #2;
        RST_I = 1;
        #1;
        chk("t5_stb", 32'(STB_O), 0);
        chk("t5_we", 32'(WE_O), 0);
        chk("t5_dat", DAT_O, 0);
        chk("t5_count", 32'(count), 0);
        chk("t5_empty", 32'(empty), 1);
        @(posedge CLK_I);
        #1;
        RST_I = 0;
        base  = wlog_d.size();
        repeat (20) tick();
        chk("t5_nowrite", 32'(wlog_d.size() - base), 0);
        chk("t5_busy", 32'(busy), 0);

`ifdef UART_TX_BRIDGE_IRQ_EN
        base = irq_cnt;
        for (int i = 0; i < 2; i++) begin
            wr_en   = 1;
            wr_data = 8'(8'h60 + i);
            tick();
        end
        wr_en = 0;
        wait_idle(60, "t6_idle");
        tick();
        chk("t6_irq_pulses", 32'(irq_cnt - base), 1);
`endif

        // random traffic: slow then bursty pushes, random ACK/ts/clear
        for (int c = 0; c < 2500; c++) begin
            wr_en    = ($urandom_range(0, 3) == 0);
            wr_data  = 8'($urandom);
            ack_en   = ($urandom_range(0, 3) != 0);
            lsr_ts   = ($urandom_range(0, 2) != 0);
            lsr_junk = $urandom;
            ovf_clr  = ($urandom_range(0, 15) == 0);
            tick();
        end
        for (int c = 0; c < 300; c++) begin
            wr_en    = ($urandom_range(0, 3) != 0);
            wr_data  = 8'($urandom);
            ack_en   = ($urandom_range(0, 3) != 0);
            lsr_ts   = ($urandom_range(0, 3) != 0);
            lsr_junk = $urandom;
            ovf_clr  = ($urandom_range(0, 31) == 0);
            tick();
        end
        wr_en   = 0;
        ovf_clr = 0;
        ack_en  = 1;
        lsr_ts  = 1;
        wait_idle(400, "rand_drain");
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
